// File: rtl/axi_dma_twod_midend.sv
// axi_dma_twod_midend: splits 2D DMA jobs into 1D burst requests for the
// backend and folds the per-burst completions back into one pulse per job.
module axi_dma_twod_midend #(
   parameter int unsigned ADDR_WIDTH  = 64,
   parameter int unsigned REPS_WIDTH  = 32,
   parameter int unsigned OUTSTANDING = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   // 2D job request
   input  logic                  twod_valid_i,
   output logic                  twod_ready_o,
   input  logic [ADDR_WIDTH-1:0] twod_src_addr_i,
   input  logic [ADDR_WIDTH-1:0] twod_dst_addr_i,
   input  logic [ADDR_WIDTH-1:0] twod_num_bytes_i,
   input  logic [ADDR_WIDTH-1:0] twod_src_stride_i,
   input  logic [ADDR_WIDTH-1:0] twod_dst_stride_i,
   input  logic [REPS_WIDTH-1:0] twod_num_reps_i,
   input  logic                  twod_is_twod_i,
   // 1D burst request to the backend
   output logic                  burst_valid_o,
   input  logic                  burst_ready_i,
   output logic [ADDR_WIDTH-1:0] burst_src_addr_o,
   output logic [ADDR_WIDTH-1:0] burst_dst_addr_o,
   output logic [ADDR_WIDTH-1:0] burst_num_bytes_o,
   output logic                  burst_last_o,
   // completion tracking
   input  logic                  oned_complete_i,
   output logic                  twod_complete_o,
   output logic                  busy_o
);

   localparam int unsigned PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] EMIT = 1'b1;

   logic [0:0]             state_q, state_d;
   logic [ADDR_WIDTH-1:0]  src_q, src_d;
   logic [ADDR_WIDTH-1:0]  dst_q, dst_d;
   logic [ADDR_WIDTH-1:0]  bytes_q, bytes_d;
   logic [ADDR_WIDTH-1:0]  src_stride_q, src_stride_d;
   logic [ADDR_WIDTH-1:0]  dst_stride_q, dst_stride_d;
   logic [REPS_WIDTH-1:0]  rem_q, rem_d;
   logic                   valid_q, valid_d;
   logic                   last_q, last_d;
   logic                   ready_q, ready_d;
   logic                   busy_q, busy_d;
   logic                   cmpl_q, cmpl_d;

   logic [OUTSTANDING-1:0] fifo_q, fifo_d;
   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;

   logic                   push;
   logic                   pop;
   logic                   not_full_d;

   // Completion FIFO: one 'last' bit per issued burst, popped in issue order.
   always_comb begin
      fifo_d   = fifo_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cmpl_d   = 1'b0;
      push     = valid_q && burst_ready_i;
      pop      = oned_complete_i && (cnt_q != '0);
      if (push) begin
         fifo_d[wr_ptr_q] = last_q;
         wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         cmpl_d   = fifo_q[rd_ptr_q];
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      cnt_d      = cnt_q + CNT_W'(push) - CNT_W'(pop);
      not_full_d = (cnt_d != CNT_W'(OUTSTANDING));
   end

   // Job FSM: accepts a job in IDLE, walks the repetitions in EMIT.
   always_comb begin
      state_d      = state_q;
      src_d        = src_q;
      dst_d        = dst_q;
      bytes_d      = bytes_q;
      src_stride_d = src_stride_q;
      dst_stride_d = dst_stride_q;
      rem_d        = rem_q;
      valid_d      = valid_q;
      last_d       = last_q;
      case (state_q)
         IDLE: begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            if (twod_valid_i && ready_q) begin
               state_d      = EMIT;
               src_d        = twod_src_addr_i;
               dst_d        = twod_dst_addr_i;
               bytes_d      = twod_num_bytes_i;
               src_stride_d = twod_src_stride_i;
               dst_stride_d = twod_dst_stride_i;
               rem_d        = (twod_is_twod_i && (twod_num_reps_i != '0)) ?
                              twod_num_reps_i : REPS_WIDTH'(1);
               last_d       = (rem_d == REPS_WIDTH'(1));
               valid_d      = not_full_d;
            end
         end
         EMIT: begin
            if (push) begin
               src_d = src_q + src_stride_q;
               dst_d = dst_q + dst_stride_q;
               rem_d = rem_q - REPS_WIDTH'(1);
               if (last_q) begin
                  state_d = IDLE;
                  valid_d = 1'b0;
                  last_d  = 1'b0;
               end else begin
                  last_d  = (rem_d == REPS_WIDTH'(1));
                  valid_d = not_full_d;
               end
            end else if (!valid_q) begin
               // Valid is only ever raised here; once up it holds until accepted.
               valid_d = not_full_d;
            end
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
         end
      endcase
      ready_d = (state_d == IDLE);
      busy_d  = (state_d == EMIT) || (cnt_d != '0);
   end

   // State and output registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         src_q        <= '0;
         dst_q        <= '0;
         bytes_q      <= '0;
         src_stride_q <= '0;
         dst_stride_q <= '0;
         rem_q        <= '0;
         valid_q      <= 1'b0;
         last_q       <= 1'b0;
         ready_q      <= 1'b1;
         busy_q       <= 1'b0;
         cmpl_q       <= 1'b0;
         fifo_q       <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         src_q        <= src_d;
         dst_q        <= dst_d;
         bytes_q      <= bytes_d;
         src_stride_q <= src_stride_d;
         dst_stride_q <= dst_stride_d;
         rem_q        <= rem_d;
         valid_q      <= valid_d;
         last_q       <= last_d;
         ready_q      <= ready_d;
         busy_q       <= busy_d;
         cmpl_q       <= cmpl_d;
         fifo_q       <= fifo_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         cnt_q        <= cnt_d;
      end
   end

   assign twod_ready_o      = ready_q;
   assign burst_valid_o     = valid_q;
   assign burst_src_addr_o  = src_q;
   assign burst_dst_addr_o  = dst_q;
   assign burst_num_bytes_o = bytes_q;
   assign burst_last_o      = last_q;
   assign twod_complete_o   = cmpl_q;
   assign busy_o            = busy_q;

endmodule

// File: tb/tb_axi_dma_twod_midend.sv
// Scoreboard bench for axi_dma_twod_midend: directed jobs push expected bursts
// and completion pulses into queues; a negedge monitor pops and compares.
module tb_axi_dma_twod_midend;

   typedef struct packed {
      logic [63:0] src;
      logic [63:0] dst;
      logic [63:0] nb;
      logic        last;
   } burst_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        twod_valid = 1'b0;
   logic        twod_ready;
   logic [63:0] t_src = '0, t_dst = '0, t_nb = '0, t_ss = '0, t_ds = '0;
   logic [31:0] t_reps = '0;
   logic        t_is2d = 1'b0;
   logic        b_valid;
   logic        b_ready = 1'b0;
   logic [63:0] b_src, b_dst, b_nb;
   logic        b_last;
   logic        oned = 1'b0;
   logic        cmpl;
   logic        busy;

   axi_dma_twod_midend #(.ADDR_WIDTH(64), .REPS_WIDTH(32), .OUTSTANDING(16)) dut (
      .clk_i(clk), .rst_i(rst),
      .twod_valid_i(twod_valid), .twod_ready_o(twod_ready),
      .twod_src_addr_i(t_src), .twod_dst_addr_i(t_dst), .twod_num_bytes_i(t_nb),
      .twod_src_stride_i(t_ss), .twod_dst_stride_i(t_ds),
      .twod_num_reps_i(t_reps), .twod_is_twod_i(t_is2d),
      .burst_valid_o(b_valid), .burst_ready_i(b_ready),
      .burst_src_addr_o(b_src), .burst_dst_addr_o(b_dst),
      .burst_num_bytes_o(b_nb), .burst_last_o(b_last),
      .oned_complete_i(oned), .twod_complete_o(cmpl), .busy_o(busy)
   );

   always #5 clk = ~clk;

   int     total = 0;
   int     bad = 0;
   int     cyc = 0;
   int     n_bursts = 0;
   burst_t exp_q[$];
   logic   mdl_q[$];
   int     cmpl_q[$];

   logic   pv_have = 1'b0, pv_valid = 1'b0, pv_ready = 1'b0;
   burst_t pv_data;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Monitor: burst scoreboard, stable-output rule, completion pulse timing.
   always @(negedge clk) begin
      burst_t cur;
      burst_t e;
      cur = '{src: b_src, dst: b_dst, nb: b_nb, last: b_last};
      if (rst) begin
         pv_have = 1'b0;
      end else begin
         if (pv_have && pv_valid && !pv_ready) begin
            total++;
            if (!b_valid || cur != pv_data) begin
               bad++;
               $display("FAIL stable: got v=%b %h want v=1 %h", b_valid, cur, pv_data);
            end
         end
         if (b_valid && b_ready) begin
            n_bursts++;
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL burst: got unexpected %h want none", cur);
            end else begin
               e = exp_q.pop_front();
               if (cur !== e) begin
                  bad++;
                  $display("FAIL burst: got src=%h dst=%h nb=%h last=%b want src=%h dst=%h nb=%h last=%b",
                           cur.src, cur.dst, cur.nb, cur.last, e.src, e.dst, e.nb, e.last);
               end
               mdl_q.push_back(e.last);
            end
         end
         if (cmpl) begin
            total++;
            if (cmpl_q.size() == 0 || cmpl_q[0] != cyc) begin
               bad++;
               $display("FAIL complete: got pulse at cycle %0d want %0d", cyc,
                        (cmpl_q.size() == 0) ? -1 : cmpl_q[0]);
            end
            if (cmpl_q.size() > 0) void'(cmpl_q.pop_front());
         end else if (cmpl_q.size() > 0 && cmpl_q[0] <= cyc) begin
            total++;
            bad++;
            $display("FAIL complete: got no pulse want pulse at cycle %0d", cmpl_q[0]);
            void'(cmpl_q.pop_front());
         end
         pv_have  = 1'b1;
         pv_valid = b_valid;
         pv_ready = b_ready;
         pv_data  = cur;
      end
   end

   // All driver tasks start and end one time unit after a rising edge.
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic exp_burst(input logic [63:0] s, input logic [63:0] d,
                            input logic [63:0] n, input logic l);
      burst_t b;
      b = '{src: s, dst: d, nb: n, last: l};
      exp_q.push_back(b);
   endtask

   task automatic job(input logic [63:0] s, input logic [63:0] d, input logic [63:0] n,
                      input logic [63:0] ss, input logic [63:0] ds,
                      input logic [31:0] reps, input logic is2d);
      bit done;
      done = 1'b0;
      t_src = s; t_dst = d; t_nb = n; t_ss = ss; t_ds = ds; t_reps = reps; t_is2d = is2d;
      twod_valid = 1'b1;
      for (int i = 0; i < 200 && !done; i++) begin
         if (twod_ready) done = 1'b1;
         @(posedge clk);
         #1;
      end
      twod_valid = 1'b0;
      if (!done) begin
         total++;
         bad++;
         $display("FAIL job_accept: got ready=0 want ready=1 within 200 cycles");
      end
   endtask

   // One cycle of the completion input; the model pops its own FIFO copy.
   task automatic comp_cycle(input bit en);
      logic b;
      if (en) begin
         oned = 1'b1;
         if (mdl_q.size() > 0) begin
            b = mdl_q.pop_front();
            if (b) cmpl_q.push_back(cyc + 1);
         end
      end
      @(posedge clk);
      #1;
      oned = 1'b0;
   endtask

   task automatic end_chk(input string name);
      chk({name, "_bursts_left"}, 64'(exp_q.size()), 64'd0);
      chk({name, "_cmpl_left"}, 64'(cmpl_q.size()), 64'd0);
      chk({name, "_busy"}, 64'(busy), 64'd0);
      chk({name, "_ready"}, 64'(twod_ready), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      idle(1);
      chk("rst_ready", 64'(twod_ready), 64'd1);
      chk("rst_valid", 64'(b_valid), 64'd0);
      chk("rst_last", 64'(b_last), 64'd0);
      chk("rst_cmpl", 64'(cmpl), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_src", b_src, 64'd0);
      chk("rst_dst", b_dst, 64'd0);
      chk("rst_nb", b_nb, 64'd0);

      // Plain 1D job
      b_ready = 1'b1;
      exp_burst(64'h1000, 64'h8000, 64'd64, 1'b1);
      job(64'h1000, 64'h8000, 64'd64, 64'h55, 64'h66, 32'd7, 1'b0);
      idle(3);
      chk("t1_busy_pending", 64'(busy), 64'd1);
      comp_cycle(1'b1);
      idle(3);
      end_chk("t1");

      // 2D job, with backend stalling the first burst
      b_ready = 1'b0;
      exp_burst(64'h100, 64'h2000, 64'd16, 1'b0);
      exp_burst(64'h140, 64'h2010, 64'd16, 1'b0);
      exp_burst(64'h180, 64'h2020, 64'd16, 1'b1);
      job(64'h100, 64'h2000, 64'd16, 64'h40, 64'h10, 32'd3, 1'b1);
      chk("t2_busy", 64'(busy), 64'd1);
      chk("t2_ready_low", 64'(twod_ready), 64'd0);
      idle(3);
      b_ready = 1'b1;
      idle(4);
      comp_cycle(1'b1);
      comp_cycle(1'b1);
      comp_cycle(1'b1);
      idle(3);
      end_chk("t2");

      // Negative stride with wrap, then reps=0 treated as one (zero bytes)
      exp_burst(64'h10, 64'h0, 64'd4, 1'b0);
      exp_burst(64'hFFFF_FFFF_FFFF_FFF0, 64'h0, 64'd4, 1'b1);
      job(64'h10, 64'h0, 64'd4, 64'hFFFF_FFFF_FFFF_FFE0, 64'h0, 32'd2, 1'b1);
      exp_burst(64'h300, 64'h400, 64'd0, 1'b1);
      job(64'h300, 64'h400, 64'd0, 64'h10, 64'h10, 32'd0, 1'b1);
      idle(3);
      comp_cycle(1'b1);
      comp_cycle(1'b1);
      comp_cycle(1'b1);
      idle(3);
      end_chk("t3");

      // Outstanding limit: 40 reps, no completions
      base = n_bursts;
      for (int i = 0; i < 40; i++)
         exp_burst(64'(i) * 64'h10, 64'h1000 + 64'(i) * 64'h20, 64'd8, i == 39);
      job(64'h0, 64'h1000, 64'd8, 64'h10, 64'h20, 32'd40, 1'b1);
      idle(40);
      chk("t4_full_count", 64'(n_bursts - base), 64'd16);
      chk("t4_full_valid", 64'(b_valid), 64'd0);
      comp_cycle(1'b1);
      idle(6);
      chk("t4_one_more", 64'(n_bursts - base), 64'd17);
      chk("t4_one_more_valid", 64'(b_valid), 64'd0);
      comp_cycle(1'b1);
      comp_cycle(1'b1);
      idle(6);
      chk("t4_push_pop", 64'(n_bursts - base), 64'd19);
      chk("t4_push_pop_valid", 64'(b_valid), 64'd0);
      for (int i = 0; i < 300; i++) begin
         if (n_bursts - base >= 40 && mdl_q.size() == 0) break;
         comp_cycle(mdl_q.size() > 0);
      end
      idle(3);
      chk("t4_total", 64'(n_bursts - base), 64'd40);
      end_chk("t4");

      // Back-to-back jobs with interleaved completions, then stray pulse
      exp_burst(64'hA00, 64'hB00, 64'd32, 1'b0);
      exp_burst(64'hA80, 64'hB40, 64'd32, 1'b1);
      job(64'hA00, 64'hB00, 64'd32, 64'h80, 64'h40, 32'd2, 1'b1);
      idle(3);
      comp_cycle(1'b1);
      exp_burst(64'hC00, 64'hD00, 64'd8, 1'b0);
      exp_burst(64'hC08, 64'hD08, 64'd8, 1'b1);
      job(64'hC00, 64'hD00, 64'd8, 64'h8, 64'h8, 32'd2, 1'b1);
      comp_cycle(1'b1);
      idle(3);
      comp_cycle(1'b1);
      comp_cycle(1'b1);
      idle(3);
      comp_cycle(1'b1);
      comp_cycle(1'b1);
      idle(4);
      end_chk("t5");

      // Reset in the middle of a 4-rep job
      b_ready = 1'b0;
      exp_burst(64'h5000, 64'h6000, 64'd32, 1'b0);
      exp_burst(64'h5100, 64'h6100, 64'd32, 1'b0);
      exp_burst(64'h5200, 64'h6200, 64'd32, 1'b0);
      exp_burst(64'h5300, 64'h6300, 64'd32, 1'b1);
      job(64'h5000, 64'h6000, 64'd32, 64'h100, 64'h100, 32'd4, 1'b1);
      b_ready = 1'b1;
      idle(1);
      b_ready = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("t6_async_valid", 64'(b_valid), 64'd0);
      chk("t6_async_last", 64'(b_last), 64'd0);
      chk("t6_async_busy", 64'(busy), 64'd0);
      chk("t6_async_src", b_src, 64'd0);
      chk("t6_async_cmpl", 64'(cmpl), 64'd0);
      exp_q.delete();
      mdl_q.delete();
      cmpl_q.delete();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(1);
      chk("t6_post_ready", 64'(twod_ready), 64'd1);
      chk("t6_post_busy", 64'(busy), 64'd0);
      b_ready = 1'b1;
      exp_burst(64'h7000, 64'h7100, 64'd12, 1'b1);
      job(64'h7000, 64'h7100, 64'd12, 64'h0, 64'h0, 32'd1, 1'b1);
      idle(3);
      comp_cycle(1'b1);
      idle(3);
      end_chk("t6");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
